// File: rtl/cmp_sched.sv
// rtl/cmp_sched.sv - two-requester compare scheduler sharing one signed/unsigned comparator
// Round-robin grant in IDLE, one compute cycle in CMP, response held in RESP until accepted.

module cmp_sched #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic [1:0]       sgn,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [2:0]       rsp_res,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, CMP, RESP} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             sgn_q;
  logic             idx_q;
  logic             prio_q;
  logic [1:0]       rsp_valid_q;
  logic [2:0]       rsp_res_q;
  logic             busy_q;

  logic             gnt_idx;
  logic [1:0]       grant;
  logic signed [WIDTH:0] a_x, b_x;
  logic [2:0]       cmp_res_d;

  // Lone request wins outright; the pointer only breaks ties.
  always_comb begin
    gnt_idx = (req_valid == 2'b11) ? prio_q : req_valid[1];
    grant   = 2'b00;
    if (|req_valid) grant = gnt_idx ? 2'b10 : 2'b01;
  end

  assign req_ready = (state_q == IDLE && rst_n) ? grant : 2'b00;

  // Sign-extend in signed mode, zero-extend otherwise, then one signed compare covers both.
  always_comb begin
    a_x = {sgn_q & a_q[WIDTH-1], a_q};
    b_x = {sgn_q & b_q[WIDTH-1], b_q};
    if (a_x > b_x)       cmp_res_d = 3'b100;
    else if (a_x == b_x) cmp_res_d = 3'b010;
    else                 cmp_res_d = 3'b001;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sgn_q       <= 1'b0;
      idx_q       <= 1'b0;
      prio_q      <= 1'b0;
      rsp_valid_q <= 2'b00;
      rsp_res_q   <= 3'b000;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|req_valid) begin
            a_q     <= gnt_idx ? a1 : a0;
            b_q     <= gnt_idx ? b1 : b0;
            sgn_q   <= sgn[gnt_idx];
            idx_q   <= gnt_idx;
            prio_q  <= ~gnt_idx;
            busy_q  <= 1'b1;
            state_q <= CMP;
          end
        end
        CMP: begin
          rsp_res_q   <= cmp_res_d;
          rsp_valid_q <= idx_q ? 2'b10 : 2'b01;
          state_q     <= RESP;
        end
        RESP: begin
          if (rsp_ready[idx_q]) begin
            rsp_valid_q <= 2'b00;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          rsp_valid_q <= 2'b00;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_res   = rsp_res_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_cmp_sched.sv
// tb/tb_cmp_sched.sv - randomized bench for cmp_sched against an arithmetic reference model
// Drives a WIDTH=32 instance and a WIDTH=4 instance from one clock and reset.

module tb_cmp_sched;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid, req_ready, sgn, rsp_valid, rsp_ready;
  logic [31:0] a0, b0, a1, b1;
  logic [2:0]  rsp_res;
  logic        busy;

  logic [1:0]  req_valid4, req_ready4, sgn4, rsp_valid4, rsp_ready4;
  logic [3:0]  a04, b04, a14, b14;
  logic [2:0]  rsp_res4;
  logic        busy4;

  int   n_checks = 0;
  int   n_errors = 0;
  logic prio_m;

  cmp_sched #(.WIDTH(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1), .sgn(sgn),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_res(rsp_res), .busy(busy)
  );

  cmp_sched #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid4), .req_ready(req_ready4),
    .a0(a04), .b0(b04), .a1(a14), .b1(b14), .sgn(sgn4),
    .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready4), .rsp_res(rsp_res4), .busy(busy4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Operands interpreted as integers of width w; signed mode subtracts 2^w when the MSB is set.
  function automatic logic [2:0] ref_cmp(input logic [63:0] a, input logic [63:0] b,
                                         input logic s, input int w);
    longint va, vb;
    va = longint'(a);
    vb = longint'(b);
    if (s && a[w-1]) va = va - (longint'(1) << w);
    if (s && b[w-1]) vb = vb - (longint'(1) << w);
    if (va > vb)  return 3'b100;
    if (va == vb) return 3'b010;
    return 3'b001;
  endfunction

  task automatic run_txn(input logic [1:0] rv, input logic [31:0] ta0, input logic [31:0] tb0,
                         input logic [31:0] ta1, input logic [31:0] tb1, input logic [1:0] ts,
                         input int hold);
    logic       idx;
    logic [1:0] oh, rr;
    logic [2:0] er;
    req_valid = rv; a0 = ta0; b0 = tb0; a1 = ta1; b1 = tb1; sgn = ts; rsp_ready = 2'b00;
    #1;
    idx = (rv == 2'b11) ? prio_m : rv[1];
    oh  = idx ? 2'b10 : 2'b01;
    er  = idx ? ref_cmp(ta1, tb1, ts[1], 32) : ref_cmp(ta0, tb0, ts[0], 32);
    check("grant", req_ready, oh);
    @(posedge clk); #1;
    prio_m = ~idx;
    check("cmp_busy", busy, 1'b1);
    check("cmp_rsp_valid", rsp_valid, 2'b00);
    check("cmp_req_ready", req_ready, 2'b00);
    a0 = ~ta0; b0 = $urandom; a1 = $urandom; b1 = ~tb1; sgn = ~ts;
    rr = 2'($urandom);
    rsp_ready = (hold == 0) ? 2'b11 : (~oh & rr);
    @(posedge clk); #1;
    check("rsp_valid", rsp_valid, oh);
    check("rsp_res", rsp_res, er);
    for (int i = 0; i < hold; i++) begin
      rr = 2'($urandom);
      rsp_ready = ~oh & rr;
      @(posedge clk); #1;
      check("hold_rsp_valid", rsp_valid, oh);
      check("hold_rsp_res", rsp_res, er);
      check("hold_req_ready", req_ready, 2'b00);
      check("hold_busy", busy, 1'b1);
    end
    rr = 2'($urandom);
    rsp_ready = oh | rr;
    @(posedge clk); #1;
    check("done_rsp_valid", rsp_valid, 2'b00);
    check("done_busy", busy, 1'b0);
  endtask

  task automatic reset_in(input int stage);
    req_valid = 2'b01; a0 = 32'd1; b0 = 32'd2; sgn = 2'b00; rsp_ready = 2'b00;
    #1;
    @(posedge clk); #1;
    if (stage == 2) begin
      @(posedge clk); #1;
      check("pre_rst_rsp_valid", rsp_valid, 2'b01);
    end
    rst_n = 1'b0;
    req_valid = 2'b11;
    #1;
    check("rst_rsp_valid", rsp_valid, 2'b00);
    check("rst_rsp_res", rsp_res, 3'b000);
    check("rst_busy", busy, 1'b0);
    check("rst_req_ready", req_ready, 2'b00);
    prio_m = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    repeat (3) begin
      @(posedge clk); #1;
      check("stale_rsp_valid", rsp_valid, 2'b00);
      check("stale_busy", busy, 1'b0);
    end
  endtask

  task automatic run4(input logic [3:0] ta, input logic [3:0] tb, input logic ts,
                      input logic [2:0] exp);
    req_valid4 = 2'b01; a04 = ta; b04 = tb; sgn4 = {1'b0, ts}; rsp_ready4 = 2'b01;
    #1;
    check("w4_grant", req_ready4, 2'b01);
    @(posedge clk); #1;
    req_valid4 = 2'b00; a04 = ~ta; b04 = ta; sgn4 = {1'b0, ~ts};
    check("w4_cmp_rsp_valid", rsp_valid4, 2'b00);
    @(posedge clk); #1;
    check("w4_rsp_valid", rsp_valid4, 2'b01);
    check("w4_rsp_res", rsp_res4, exp);
    @(posedge clk); #1;
    check("w4_done", rsp_valid4, 2'b00);
  endtask

  initial begin
    logic [3:0]  ra, rb;
    logic        rs;
    logic [31:0] x;
    rst_n = 1'b0; prio_m = 1'b0;
    req_valid = 2'b11; a0 = '0; b0 = '0; a1 = '0; b1 = '0; sgn = 2'b00; rsp_ready = 2'b00;
    req_valid4 = 2'b11; a04 = '0; b04 = '0; a14 = '0; b14 = '0; sgn4 = 2'b00; rsp_ready4 = 2'b00;
    repeat (2) @(negedge clk);
    check("reset_req_ready", req_ready, 2'b00);
    check("reset_rsp_valid", rsp_valid, 2'b00);
    check("reset_rsp_res", rsp_res, 3'b000);
    check("reset_busy", busy, 1'b0);
    check("reset_req_ready4", req_ready4, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    req_valid4 = 2'b00;

    for (int i = 0; i < 4; i++)
      run_txn(2'b11, $urandom, $urandom, $urandom, $urandom, 2'($urandom), 0);

    run_txn(2'b01, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0, 32'h0, 2'b01, 0);
    run_txn(2'b01, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0, 32'h0, 2'b00, 0);
    run_txn(2'b10, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b10, 0);
    run_txn(2'b10, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, 1);
    run_txn(2'b01, $urandom, $urandom, $urandom, $urandom, 2'b11, 5);

    for (int i = 0; i < 40; i++) begin
      x = $urandom;
      run_txn(2'($urandom_range(1, 3)), x, (i % 5 == 0) ? x : $urandom,
              $urandom, $urandom, 2'($urandom), $urandom_range(0, 3));
    end

    reset_in(1);
    run_txn(2'b11, $urandom, $urandom, $urandom, $urandom, 2'($urandom), 0);
    reset_in(2);
    run_txn(2'b11, $urandom, $urandom, $urandom, $urandom, 2'($urandom), 0);
    req_valid = 2'b00;

    run4(4'h1, 4'hF, 1'b0, 3'b001);
    run4(4'h1, 4'hF, 1'b1, 3'b100);
    run4(4'h8, 4'h7, 1'b1, 3'b001);
    run4(4'h5, 4'h5, 1'b1, 3'b010);
    for (int i = 0; i < 12; i++) begin
      ra = 4'($urandom); rb = 4'($urandom); rs = 1'($urandom);
      run4(ra, rb, rs, ref_cmp({60'd0, ra}, {60'd0, rb}, rs, 4));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
